// File: rtl/dimm_responder.sv
// rtl/dimm_responder.sv - DDR command-timing responder with per-bank state and a single burst engine.
// Rejects illegal commands with a coded error pulse and paces read/write beat windows.
module dimm_responder #(
  parameter int T_RCD   = 39,
  parameter int T_RP    = 39,
  parameter int T_RAS   = 76,
  parameter int T_CAS   = 40,
  parameter int T_CWD   = 38,
  parameter int T_BURST = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  input  logic [1:0]  cmd_op,
  input  logic [2:0]  cmd_bg,
  input  logic [1:0]  cmd_ba,
  input  logic [15:0] cmd_row,
  input  logic [9:0]  cmd_col,
  output logic        rd_valid,
  output logic        wr_window,
  output logic [2:0]  burst_bg,
  output logic [1:0]  burst_ba,
  output logic [9:0]  burst_col,
  output logic [31:0] bank_open,
  output logic        err,
  output logic [2:0]  err_code
);

  localparam logic [1:0] OP_ACT = 2'd0;
  localparam logic [1:0] OP_RD  = 2'd1;
  localparam logic [1:0] OP_WR  = 2'd2;
  localparam logic [1:0] OP_PRE = 2'd3;

  localparam logic [7:0] RCD      = 8'(T_RCD);
  localparam logic [7:0] RP       = 8'(T_RP);
  localparam logic [7:0] RAS      = 8'(T_RAS);
  localparam logic [7:0] CAS_M1   = 8'(T_CAS - 1);
  localparam logic [7:0] CWD_M1   = 8'(T_CWD - 1);
  localparam logic [7:0] BURST_M1 = 8'(T_BURST - 1);

  typedef enum logic [1:0] {IDLE, WAIT, BEAT} state_t;

  state_t      state;
  logic [7:0]  cnt;
  logic        burst_rd;
  logic [15:0] row_q   [32];
  logic [7:0]  act_cnt [32];
  logic [7:0]  pre_cnt [32];

  logic [4:0]  idx;
  logic [7:0]  act_el;
  logic [7:0]  pre_el;
  logic        busy;
  logic        reject;
  logic [2:0]  code;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hff) ? v : v + 8'd1;
  endfunction

  // Elapsed counts include the edge being evaluated, so ACT at edge 0 reads 39 at edge 39.
  // The final BEAT cycle counts as idle so a back-to-back RD/WR can be taken there.
  always_comb begin
    idx    = {cmd_bg, cmd_ba};
    act_el = sat_inc(act_cnt[idx]);
    pre_el = sat_inc(pre_cnt[idx]);
    busy   = (state == WAIT) || (state == BEAT && cnt != 8'd0);
    reject = 1'b0;
    code   = 3'd0;
    case (cmd_op)
      OP_ACT: begin
        if (bank_open[idx]) begin
          reject = 1'b1;
          code   = 3'd1;
        end else if (pre_el < RP) begin
          reject = 1'b1;
          code   = 3'd5;
        end
      end
      OP_RD, OP_WR: begin
        if (!bank_open[idx]) begin
          reject = 1'b1;
          code   = 3'd2;
        end else if (act_el < RCD) begin
          reject = 1'b1;
          code   = 3'd3;
        end else if (busy) begin
          reject = 1'b1;
          code   = 3'd6;
        end
      end
      default: begin
        if (bank_open[idx] && act_el < RAS) begin
          reject = 1'b1;
          code   = 3'd4;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        row_q[i]   <= '0;
        act_cnt[i] <= '0;
        pre_cnt[i] <= 8'hff;
      end
      bank_open <= '0;
      state     <= IDLE;
      cnt       <= '0;
      burst_rd  <= 1'b0;
      rd_valid  <= 1'b0;
      wr_window <= 1'b0;
      burst_bg  <= '0;
      burst_ba  <= '0;
      burst_col <= '0;
      err       <= 1'b0;
      err_code  <= '0;
    end else begin
      for (int i = 0; i < 32; i++) begin
        act_cnt[i] <= sat_inc(act_cnt[i]);
        pre_cnt[i] <= sat_inc(pre_cnt[i]);
      end
      err      <= 1'b0;
      err_code <= '0;

      case (state)
        WAIT: begin
          if (cnt == 8'd0) begin
            state     <= BEAT;
            cnt       <= BURST_M1;
            rd_valid  <= burst_rd;
            wr_window <= !burst_rd;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        BEAT: begin
          if (cnt == 8'd0) begin
            state     <= IDLE;
            rd_valid  <= 1'b0;
            wr_window <= 1'b0;
            burst_bg  <= '0;
            burst_ba  <= '0;
            burst_col <= '0;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        default: state <= IDLE;
      endcase

      // Accepted commands are applied last so they override the burst engine's own updates.
      if (cmd_valid) begin
        if (reject) begin
          err      <= 1'b1;
          err_code <= code;
        end else begin
          case (cmd_op)
            OP_ACT: begin
              bank_open[idx] <= 1'b1;
              row_q[idx]     <= cmd_row;
              act_cnt[idx]   <= '0;
            end
            OP_RD, OP_WR: begin
              state     <= WAIT;
              cnt       <= (cmd_op == OP_RD) ? CAS_M1 : CWD_M1;
              burst_rd  <= (cmd_op == OP_RD);
              burst_bg  <= cmd_bg;
              burst_ba  <= cmd_ba;
              burst_col <= cmd_col;
            end
            default: begin
              if (bank_open[idx]) begin
                bank_open[idx] <= 1'b0;
                pre_cnt[idx]   <= '0;
              end
            end
          endcase
        end
      end
    end
  end

endmodule
